// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and data-memory wait
// handling with a timeout that parks the pipeline in a sticky ERROR state.
module pipeline_hazard_controller #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255,
  parameter int         STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   MemRead_EX_i,
  input  logic [4:0]             RDaddr_EX_i,
  input  logic [4:0]             RS1addr_ID_i,
  input  logic [4:0]             RS2addr_ID_i,
  input  logic                   Branch_taken_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ack_i,
  output logic                   PCWrite_o,
  output logic                   IFID_Write_o,
  output logic                   IFID_Flush_o,
  output logic                   NoOp_o,
  output logic                   Freeze_o,
  output logic                   err_o,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10,
    ILLEGAL  = 2'b11
  } stateT;

  localparam logic [7:0] TIMEOUT_LAST = MEM_TIMEOUT - 8'd1;

  stateT                  stateReg, stateNext;
  logic [7:0]             waitCntReg, waitCntNext;
  logic [STALL_CNT_W-1:0] stallCntReg;
  logic                   loadUse;

  assign loadUse = MemRead_EX_i && (RDaddr_EX_i != 5'd0) &&
                   ((RDaddr_EX_i == RS1addr_ID_i) || (RDaddr_EX_i == RS2addr_ID_i));

  always_comb begin
    stateNext    = stateReg;
    waitCntNext  = waitCntReg;
    PCWrite_o    = 1'b0;
    IFID_Write_o = 1'b0;
    IFID_Flush_o = 1'b0;
    NoOp_o       = 1'b0;
    Freeze_o     = 1'b0;
    case (stateReg)
      RUN, MEM_WAIT: begin
        if (stateReg == RUN && mem_req_i && !mem_ack_i) begin
          Freeze_o    = 1'b1;
          waitCntNext = 8'd0;
          stateNext   = MEM_WAIT;
        end else if (stateReg == MEM_WAIT && !mem_ack_i) begin
          Freeze_o    = 1'b1;
          waitCntNext = waitCntReg + 8'd1;
          if (waitCntReg == TIMEOUT_LAST)
            stateNext = ERROR;
        end else begin
          // Ack cycle and plain RUN share the hazard resolution; a stalled
          // ID instruction re-presents its branch, so lu masks the flush.
          NoOp_o       = loadUse;
          PCWrite_o    = !loadUse;
          IFID_Write_o = !loadUse;
          IFID_Flush_o = !loadUse && Branch_taken_i;
          waitCntNext  = 8'd0;
          stateNext    = RUN;
        end
      end
      default: begin
        Freeze_o  = 1'b1;
        stateNext = ERROR;
      end
    endcase
    if (!rst_i) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      IFID_Flush_o = 1'b0;
      NoOp_o       = 1'b0;
      Freeze_o     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stateReg    <= RUN;
      waitCntReg  <= 8'd0;
      stallCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      if (!PCWrite_o && !stateReg[1] && (stallCntReg != '1))
        stallCntReg <= stallCntReg + STALL_CNT_W'(1);
    end
  end

  assign err_o       = stateReg[1];
  assign state_o     = stateReg;
  assign stall_cnt_o = stallCntReg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a default instance plus a second
// instance with MEM_TIMEOUT=4 and a 4-bit stall counter for timeout/saturation cases.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rstN;
  logic       memRead, branch, memReq, memAck;
  logic [4:0] rdEx, rs1Id, rs2Id;

  logic        pcW, ifidW, flush, noOp, freeze, err;
  logic [1:0]  state;
  logic [15:0] stallCnt;
  logic        pcW2, ifidW2, flush2, noOp2, freeze2, err2;
  logic [1:0]  state2;
  logic [3:0]  stallCnt2;

  // Control vector order: {PCWrite, IFID_Write, IFID_Flush, NoOp, Freeze}
  logic [4:0] ctl, ctl2;
  assign ctl  = {pcW, ifidW, flush, noOp, freeze};
  assign ctl2 = {pcW2, ifidW2, flush2, noOp2, freeze2};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk_i(clk), .rst_i(rstN), .MemRead_EX_i(memRead), .RDaddr_EX_i(rdEx),
    .RS1addr_ID_i(rs1Id), .RS2addr_ID_i(rs2Id), .Branch_taken_i(branch),
    .mem_req_i(memReq), .mem_ack_i(memAck), .PCWrite_o(pcW), .IFID_Write_o(ifidW),
    .IFID_Flush_o(flush), .NoOp_o(noOp), .Freeze_o(freeze), .err_o(err),
    .state_o(state), .stall_cnt_o(stallCnt)
  );

  pipeline_hazard_controller #(.MEM_TIMEOUT(8'd4), .STALL_CNT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rstN), .MemRead_EX_i(memRead), .RDaddr_EX_i(rdEx),
    .RS1addr_ID_i(rs1Id), .RS2addr_ID_i(rs2Id), .Branch_taken_i(branch),
    .mem_req_i(memReq), .mem_ack_i(memAck), .PCWrite_o(pcW2), .IFID_Write_o(ifidW2),
    .IFID_Flush_o(flush2), .NoOp_o(noOp2), .Freeze_o(freeze2), .err_o(err2),
    .state_o(state2), .stall_cnt_o(stallCnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    memRead = 1'b0; branch = 1'b0; memReq = 1'b0; memAck = 1'b0;
    rdEx = 5'd0; rs1Id = 5'd0; rs2Id = 5'd0;
  endtask

  task automatic doReset();
    clearInputs();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    memReq = 1'b1; memAck = 1'b0; memRead = 1'b1; rdEx = 5'd5; rs1Id = 5'd5; branch = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 5'b00000); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected %b", state, 2'b00); end
    checks++; if (stallCnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected %0d", stallCnt, 0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
    tick();
    checks++; if (stallCnt !== 16'd0 || state !== 2'b00) begin errors++; $display("FAIL reset_hold: got cnt=%0d state=%b expected cnt=0 state=00", stallCnt, state); end
    $display("txn reset: ctl=%b state=%b cnt=%0d", ctl, state, stallCnt);
    doReset();
  endtask

  task automatic test_load_use();
    doReset();
    memRead = 1'b1; rdEx = 5'd5; rs1Id = 5'd5; rs2Id = 5'd0;
    #1;
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL lu_rs1_ctl: got %b expected %b", ctl, 5'b00010); end
    tick();
    checks++; if (stallCnt !== 16'd1) begin errors++; $display("FAIL lu_rs1_cnt: got %0d expected %0d", stallCnt, 1); end
    rs1Id = 5'd0; rs2Id = 5'd5;
    #1;
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL lu_rs2_ctl: got %b expected %b", ctl, 5'b00010); end
    tick();
    checks++; if (stallCnt !== 16'd2 || state !== 2'b00) begin errors++; $display("FAIL lu_rs2_cnt: got cnt=%0d state=%b expected cnt=2 state=00", stallCnt, state); end
    $display("txn load_use: cnt=%0d", stallCnt);
  endtask

  task automatic test_no_hazard();
    doReset();
    memRead = 1'b1; rdEx = 5'd0; rs1Id = 5'd0; rs2Id = 5'd0;
    #1;
    checks++; if (ctl !== 5'b11000) begin errors++; $display("FAIL x0_ctl: got %b expected %b", ctl, 5'b11000); end
    tick();
    rdEx = 5'd3; rs1Id = 5'd4; rs2Id = 5'd6;
    #1;
    checks++; if (ctl !== 5'b11000) begin errors++; $display("FAIL nomatch_ctl: got %b expected %b", ctl, 5'b11000); end
    tick();
    memRead = 1'b0; rdEx = 5'd5; rs1Id = 5'd5;
    #1;
    checks++; if (ctl !== 5'b11000) begin errors++; $display("FAIL noload_ctl: got %b expected %b", ctl, 5'b11000); end
    tick();
    checks++; if (stallCnt !== 16'd0) begin errors++; $display("FAIL nohaz_cnt: got %0d expected %0d", stallCnt, 0); end
    $display("txn no_hazard: cnt=%0d", stallCnt);
  endtask

  task automatic test_mem_wait();
    doReset();
    memReq = 1'b1; memAck = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00001 || state !== 2'b00) begin errors++; $display("FAIL mw_issue: got ctl=%b state=%b expected ctl=00001 state=00", ctl, state); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ctl !== 5'b00001 || state !== 2'b01) begin errors++; $display("FAIL mw_wait%0d: got ctl=%b state=%b expected ctl=00001 state=01", i, ctl, state); end
    end
    tick();
    memAck = 1'b1;
    #1;
    checks++; if (ctl !== 5'b11000 || state !== 2'b01) begin errors++; $display("FAIL mw_ack: got ctl=%b state=%b expected ctl=11000 state=01", ctl, state); end
    tick();
    checks++; if (state !== 2'b00 || stallCnt !== 16'd3) begin errors++; $display("FAIL mw_done: got state=%b cnt=%0d expected state=00 cnt=3", state, stallCnt); end
    // Single-cycle access: req and ack together in RUN
    #1;
    checks++; if (ctl !== 5'b11000) begin errors++; $display("FAIL single_ctl: got %b expected %b", ctl, 5'b11000); end
    tick();
    checks++; if (state !== 2'b00 || stallCnt !== 16'd3) begin errors++; $display("FAIL single_done: got state=%b cnt=%0d expected state=00 cnt=3", state, stallCnt); end
    memAck = 1'b0;
    tick();
    memAck = 1'b1; memRead = 1'b1; rdEx = 5'd9; rs2Id = 5'd9;
    #1;
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL mw_ack_lu: got %b expected %b", ctl, 5'b00010); end
    tick();
    checks++; if (state !== 2'b00 || stallCnt !== 16'd5) begin errors++; $display("FAIL mw_ack_lu_done: got state=%b cnt=%0d expected state=00 cnt=5", state, stallCnt); end
    $display("txn mem_wait: state=%b cnt=%0d", state, stallCnt);
  endtask

  task automatic test_priority();
    doReset();
    memRead = 1'b1; rdEx = 5'd7; rs1Id = 5'd7; branch = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL pri_lu_br: got %b expected %b", ctl, 5'b00010); end
    tick();
    memRead = 1'b0;
    #1;
    checks++; if (ctl !== 5'b11100) begin errors++; $display("FAIL pri_br: got %b expected %b", ctl, 5'b11100); end
    tick();
    memRead = 1'b1; memReq = 1'b1; memAck = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL pri_mem: got %b expected %b", ctl, 5'b00001); end
    tick();
    memRead = 1'b0; memAck = 1'b1;
    #1;
    checks++; if (ctl !== 5'b11100 || state !== 2'b01) begin errors++; $display("FAIL pri_ack_br: got ctl=%b state=%b expected ctl=11100 state=01", ctl, state); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL pri_done: got %b expected %b", state, 2'b00); end
    $display("txn priority: state=%b cnt=%0d", state, stallCnt);
  endtask

  task automatic test_timeout();
    doReset();
    memReq = 1'b1; memAck = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (state2 !== 2'b01 || err2 !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got state=%b err=%b expected state=01 err=0", i, state2, err2); end
      tick();
    end
    checks++; if (state2 !== 2'b10 || err2 !== 1'b1 || ctl2 !== 5'b00001) begin errors++; $display("FAIL to_error: got state=%b err=%b ctl=%b expected 10 1 00001", state2, err2, ctl2); end
    checks++; if (stallCnt2 !== 4'd5) begin errors++; $display("FAIL to_cnt: got %0d expected %0d", stallCnt2, 5); end
    checks++; if (state !== 2'b01 || err !== 1'b0) begin errors++; $display("FAIL to_default_wait: got state=%b err=%b expected 01 0", state, err); end
    memAck = 1'b1; memReq = 1'b0;
    tick();
    tick();
    checks++; if (state2 !== 2'b10 || err2 !== 1'b1 || stallCnt2 !== 4'd5) begin errors++; $display("FAIL to_sticky: got state=%b err=%b cnt=%0d expected 10 1 5", state2, err2, stallCnt2); end
    rstN = 1'b0;
    #1;
    checks++; if (ctl2 !== 5'b00000) begin errors++; $display("FAIL to_rst_ctl: got %b expected %b", ctl2, 5'b00000); end
    tick();
    checks++; if (state2 !== 2'b00 || err2 !== 1'b0 || stallCnt2 !== 4'd0) begin errors++; $display("FAIL to_rst: got state=%b err=%b cnt=%0d expected 00 0 0", state2, err2, stallCnt2); end
    $display("txn timeout: state2=%b err2=%b", state2, err2);
    // Ack arriving in the last permitted wait cycle beats the timeout
    doReset();
    memReq = 1'b1; memAck = 1'b0;
    tick();
    tick();
    tick();
    tick();
    memAck = 1'b1;
    #1;
    checks++; if (ctl2 !== 5'b11000 || state2 !== 2'b01) begin errors++; $display("FAIL to_ack_last: got ctl=%b state=%b expected 11000 01", ctl2, state2); end
    tick();
    checks++; if (state2 !== 2'b00 || err2 !== 1'b0) begin errors++; $display("FAIL to_ack_win: got state=%b err=%b expected 00 0", state2, err2); end
    $display("txn ack_vs_timeout: state2=%b err2=%b", state2, err2);
  endtask

  task automatic test_saturation_reset();
    doReset();
    memRead = 1'b1; rdEx = 5'd12; rs1Id = 5'd12;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (stallCnt2 !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d expected %0d", stallCnt2, 15); end
    checks++; if (stallCnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d expected %0d", stallCnt, 20); end
    clearInputs();
    memReq = 1'b1;
    tick();
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL midwait_state: got %b expected %b", state, 2'b01); end
    rstN = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL midwait_rst_ctl: got %b expected %b", ctl, 5'b00000); end
    tick();
    checks++; if (state !== 2'b00 || stallCnt !== 16'd0) begin errors++; $display("FAIL midwait_rst: got state=%b cnt=%0d expected 00 0", state, stallCnt); end
    rstN = 1'b1; memReq = 1'b0;
    #1;
    checks++; if (ctl !== 5'b11000) begin errors++; $display("FAIL post_rst_ctl: got %b expected %b", ctl, 5'b11000); end
    tick();
    checks++; if (state !== 2'b00 || stallCnt !== 16'd0) begin errors++; $display("FAIL post_rst: got state=%b cnt=%0d expected 00 0", state, stallCnt); end
    $display("txn saturation_reset: cnt4=%0d state=%b", stallCnt2, state);
  endtask

  initial begin
    clearInputs();
    rstN = 1'b0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_priority();
    test_timeout();
    test_saturation_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 8'd255; maximum MEM_WAIT cycles tolerated before ERROR.
REQ-002 Parameter: STALL_CNT_W, default 16; width of stall_cnt_o.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-low.
REQ-005 MemRead_EX_i  in  1  instruction in EX is a load.
REQ-006 RDaddr_EX_i  in  5  destination register of the EX instruction.
REQ-007 RS1addr_ID_i, RS2addr_ID_i  in  5 each  source registers of the ID instruction.
REQ-008 Branch_taken_i  in  1  ID-stage branch resolved taken.
REQ-009 mem_req_i  in  1  MEM stage issuing a data-memory access this cycle.
REQ-010 mem_ack_i  in  1  data memory completes the outstanding access this cycle.
REQ-011 PCWrite_o  out  1  PC update enable.
REQ-012 IFID_Write_o  out  1  IF/ID register write enable.
REQ-013 IFID_Flush_o  out  1  clear IF/ID to a NOP.
REQ-014 NoOp_o  out  1  insert a bubble into ID/EX.
REQ-015 Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB registers.
REQ-016 err_o  out  1  sticky memory-timeout error.
REQ-017 state_o  out  2  current FSM state encoding.
REQ-018 stall_cnt_o  out  STALL_CNT_W  count of stalled cycles.

Function
REQ-019 States SHALL be RUN=2'b00, MEM_WAIT=2'b01 and ERROR=2'b10; 2'b11 is unreachable and SHALL behave as ERROR.
REQ-020 The load-use hazard term SHALL be lu = MemRead_EX_i & (RDaddr_EX_i != 0) & ((RDaddr_EX_i == RS1addr_ID_i) | (RDaddr_EX_i == RS2addr_ID_i)).
REQ-021 Outputs SHALL be combinational from the state and the current inputs (Mealy), with no added latency.
REQ-022 RUN, condition mem_req_i & ~mem_ack_i (highest priority): PCWrite_o=0, IFID_Write_o=0, Freeze_o=1, NoOp_o=0, IFID_Flush_o=0; next state MEM_WAIT.
REQ-023 RUN, otherwise if lu: PCWrite_o=0, IFID_Write_o=0, NoOp_o=1, Freeze_o=0, IFID_Flush_o=0; stay in RUN; any coincident Branch_taken_i is ignored, because the held ID instruction re-presents it.
REQ-024 RUN, otherwise if Branch_taken_i: PCWrite_o=1, IFID_Write_o=1, IFID_Flush_o=1, NoOp_o=0, Freeze_o=0.
REQ-025 RUN, otherwise: PCWrite_o=1, IFID_Write_o=1, all other control outputs 0.
REQ-026 MEM_WAIT with mem_ack_i=0: outputs SHALL be as in REQ-022; the wait counter increments; if the counter equals MEM_TIMEOUT-1 in this cycle, next state SHALL be ERROR.
REQ-027 MEM_WAIT with mem_ack_i=1: Freeze_o=0; the remaining outputs SHALL follow REQ-023 to REQ-025 (ack wins over timeout in the same cycle); the wait counter clears; next state RUN.
REQ-028 ERROR: PCWrite_o=0, IFID_Write_o=0, Freeze_o=1, NoOp_o=0, IFID_Flush_o=0, err_o=1; exited only by reset.
REQ-029 The wait counter is 8 bits and clears on every entry to MEM_WAIT.
REQ-030 stall_cnt_o SHALL increment by 1 on each clock edge where PCWrite_o=0 and state is not ERROR, and SHALL saturate at all-ones with no wrap.
REQ-031 A single-cycle access (mem_req_i and mem_ack_i both 1 in RUN) SHALL cause no stall.

Reset
REQ-032 When rst_i=0 at a rising edge: state becomes RUN, wait counter 0, stall_cnt_o 0, err_o 0.
REQ-033 While rst_i=0: PCWrite_o, IFID_Write_o, NoOp_o, IFID_Flush_o and Freeze_o SHALL all be 0, and no counter advances.
REQ-034 A reset asserted mid-MEM_WAIT or in ERROR SHALL abandon the access; after reset release the block is in RUN with no pending state.

Verification
REQ-035 Load-use: MemRead_EX_i=1, RD=5, RS1=5 in RUN -> that cycle NoOp_o=1, PCWrite_o=0, IFID_Write_o=0; stall_cnt_o = 1 at the next edge.
REQ-036 x0 and no match: MemRead_EX_i=1, RD=0, RS2=0 -> NoOp_o=0, PCWrite_o=1; repeat with RD=3, RS1=4, RS2=6 -> no stall.
REQ-037 Memory wait: mem_req_i=1 with ack held 0 for 3 cycles, then 1 -> Freeze_o=1 for 3 cycles with state_o=01, release in the ack cycle, stall_cnt_o=3.
REQ-038 Timeout: MEM_TIMEOUT=4, mem_req_i=1 and never ack -> state_o=10 and err_o=1 after 4 wait cycles, persisting until rst_i=0.
REQ-039 Priority: lu and Branch_taken_i together -> NoOp_o=1, IFID_Flush_o=0; next cycle with lu=0 and branch still 1 -> IFID_Flush_o=1.
REQ-040 Saturation and reset: STALL_CNT_W=4 with 20 stall cycles -> stall_cnt_o=15; rst_i=0 mid-MEM_WAIT -> state_o=00, stall_cnt_o=0 at the next edge.
